// File: rtl/trace_feeder.sv
// Trace feeder: replays a loaded buffer of addresses to a cache, one access
// at a time. An access completes when the cache's hit+miss total moves. The
// block also measures per-access latency and flags accesses that stall.
module trace_feeder #(
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 63
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_en,
   input  logic [$clog2(DEPTH)-1:0]   load_addr,
   input  logic [15:0]                load_data,
   input  logic                       start,
   input  logic [$clog2(DEPTH):0]     trace_len,
   input  logic [15:0]                cache_hit_count,
   input  logic [15:0]                cache_miss_count,
   output logic [15:0]                memory_trace,
   output logic                       trace_ready,
   output logic                       busy,
   output logic                       run_done,
   output logic                       timeout_err,
   output logic [15:0]                issued_count,
   output logic [7:0]                 max_latency
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FIN, ERR} state_t;

   state_t        state;
   logic [15:0]   trace_buf [DEPTH];
   logic [AW-1:0] ptr;
   logic [LW-1:0] len;
   logic [LW-1:0] len_clamped;
   logic [LW-1:0] ptr_inc;
   logic [15:0]   snap;
   logic [15:0]   sum;
   logic [15:0]   lat;
   logic [16:0]   lat_total;
   logic [7:0]    lat_sat;
   logic          done_access;

   // Completion is any change of the 16-bit wrapped total, however large
   assign sum         = cache_hit_count + cache_miss_count;
   assign done_access = (sum != snap);
   // lat counts WAIT cycles before the completing one; +2 adds the ISSUE
   // cycle and the completing cycle itself
   assign lat_total   = {1'b0, lat} + 17'd2;
   assign lat_sat     = (lat_total > 17'd255) ? 8'hFF : lat_total[7:0];
   assign ptr_inc     = {1'b0, ptr} + LW'(1);
   assign len_clamped = (trace_len > LW'(DEPTH)) ? LW'(DEPTH) : trace_len;

   // Trace buffer: no reset so contents survive it; writable only when idle
   always_ff @(posedge clk) begin
      if (load_en && state == IDLE)
         trace_buf[load_addr] <= load_data;
   end

   // Run sequencer with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         memory_trace <= '0;
         trace_ready  <= 1'b0;
         busy         <= 1'b0;
         run_done     <= 1'b0;
         timeout_err  <= 1'b0;
         issued_count <= '0;
         max_latency  <= '0;
         ptr          <= '0;
         len          <= '0;
         snap         <= '0;
         lat          <= '0;
      end else begin
         run_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  issued_count <= '0;
                  max_latency  <= '0;
                  timeout_err  <= 1'b0;
                  ptr          <= '0;
                  if (trace_len == '0) begin
                     state <= FIN;
                  end else begin
                     len   <= len_clamped;
                     snap  <= sum;
                     busy  <= 1'b1;
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               memory_trace <= trace_buf[ptr];
               trace_ready  <= 1'b1;
               lat          <= '0;
               state        <= WAIT;
            end
            WAIT: begin
               if (done_access) begin
                  snap         <= sum;
                  issued_count <= issued_count + 16'd1;
                  if (lat_sat > max_latency)
                     max_latency <= lat_sat;
                  trace_ready  <= 1'b0;
                  state        <= GAP;
               end else if (lat == 16'(TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  trace_ready <= 1'b0;
                  busy        <= 1'b0;
                  state       <= ERR;
               end else begin
                  lat <= lat + 16'd1;
               end
            end
            GAP: begin
               ptr <= ptr + AW'(1);
               if (ptr_inc == len) begin
                  busy  <= 1'b0;
                  state <= FIN;
               end else begin
                  state <= ISSUE;
               end
            end
            FIN, ERR: begin
               run_done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_feeder.sv
// Bench for trace_feeder: table of replay runs plus hand sequences for
// zero-length start, reset mid-access and writes/starts while busy.
module tb_trace_feeder;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 12;
   localparam int AW      = 3;
   localparam int LW      = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [15:0]   load_data = '0;
   logic          start = 1'b0;
   logic [LW-1:0] trace_len = '0;
   logic [15:0]   cache_hit_count = '0;
   logic [15:0]   cache_miss_count = '0;
   logic [15:0]   memory_trace;
   logic          trace_ready;
   logic          busy;
   logic          run_done;
   logic          timeout_err;
   logic [15:0]   issued_count;
   logic [7:0]    max_latency;

   trace_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .trace_len(trace_len),
      .cache_hit_count(cache_hit_count), .cache_miss_count(cache_miss_count),
      .memory_trace(memory_trace), .trace_ready(trace_ready), .busy(busy),
      .run_done(run_done), .timeout_err(timeout_err),
      .issued_count(issued_count), .max_latency(max_latency));

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_addr_q[$];
   int          exp_win_q[$];
   int          resp_q[$];
   logic [15:0] bump = 16'd1;
   int          done_cnt = 0;

   typedef struct {
      logic [LW-1:0]     len;
      logic [15:0]       pre_hit;
      logic [15:0]       step;
      logic [7:0][15:0]  addr;
      logic [7:0][7:0]   lat;     // 0 = cache never answers
      int                x_issued;
      int                x_max;
      int                x_terr;
   } run_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic run_t mk(input logic [LW-1:0] len, input logic [15:0] ph,
                               input logic [15:0] st, input int xi, input int xm, input int xt);
      run_t r;
      r.len = len; r.pre_hit = ph; r.step = st;
      r.addr = '0; r.lat = '0;
      r.x_issued = xi; r.x_max = xm; r.x_terr = xt;
      return r;
   endfunction

   // Count run_done high cycles
   always @(negedge clk) if (run_done === 1'b1) done_cnt++;

   // Window monitor: check address at each trace_ready rise, stability and window length
   logic        mon_prev = 1'b0;
   int          win_len = 0;
   logic [15:0] cur_addr = '0;
   always @(negedge clk) begin
      if (reset) begin
         mon_prev = 1'b0;
         win_len  = 0;
      end else begin
         if (trace_ready && !mon_prev) begin
            if (exp_addr_q.size() == 0) chk("unexpected_issue", 1, 0);
            else chk("issue_addr", memory_trace, exp_addr_q.pop_front());
            cur_addr = memory_trace;
            win_len  = 1;
         end else if (trace_ready) begin
            win_len++;
            chk("addr_stable", memory_trace, cur_addr);
         end else if (mon_prev) begin
            if (exp_win_q.size() == 0) chk("unexpected_window", 1, 0);
            else chk("window_len", win_len, exp_win_q.pop_front());
         end
         mon_prev = trace_ready;
      end
   end

   // Cache model: bumps hit count so completion is seen L cycles after issue
   logic rsp_prev = 1'b0;
   initial forever begin
      @(negedge clk);
      if (!reset && trace_ready && !rsp_prev) begin
         int l;
         l = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
         if (l >= 2) begin
            repeat (l - 2) @(posedge clk);
            #1 cache_hit_count = cache_hit_count + bump;
         end
      end
      rsp_prev = trace_ready;
   end

   task automatic load(input int a, input logic [15:0] d);
      @(negedge clk);
      load_en = 1'b1; load_addr = AW'(a); load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic arm(input run_t r, input bit do_load);
      int n;
      n = (int'(r.len) > DEPTH) ? DEPTH : int'(r.len);
      if (do_load) for (int i = 0; i < n; i++) load(i, r.addr[i]);
      @(negedge clk);
      cache_hit_count = r.pre_hit; cache_miss_count = 16'd0; bump = r.step;
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(r.addr[i]);
         resp_q.push_back(int'(r.lat[i]));
         exp_win_q.push_back(r.lat[i] == 0 ? TIMEOUT + 1 : int'(r.lat[i]) - 1);
         if (r.lat[i] == 0) break;
      end
      start = 1'b1; trace_len = r.len;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish(input string tag, input int xi, input int xm, input int xt);
      int cyc;
      int d0;
      cyc = 0; d0 = done_cnt;
      while (run_done !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
      chk({tag, "_run_done"}, run_done, 1);
      @(negedge clk);
      chk({tag, "_done_width"}, run_done, 0);
      chk({tag, "_done_count"}, done_cnt - d0, 1);
      chk({tag, "_issued"}, issued_count, xi);
      chk({tag, "_max_lat"}, max_latency, xm);
      chk({tag, "_timeout"}, timeout_err, xt);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, trace_ready, 0);
      chk({tag, "_addr_left"}, exp_addr_q.size(), 0);
      chk({tag, "_win_left"}, exp_win_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   run_t tbl[5];
   run_t hr;

   initial begin
      int d0;
      int cyc;

      tbl[0] = mk(4'd3, 16'h0000, 16'd1, 3, 5, 0);
      tbl[0].addr[0] = 16'h0010; tbl[0].addr[1] = 16'h0020; tbl[0].addr[2] = 16'h0010;
      tbl[0].lat[0] = 8'd5; tbl[0].lat[1] = 8'd5; tbl[0].lat[2] = 8'd5;
      tbl[1] = mk(4'd4, 16'h1234, 16'd3, 4, 7, 0);
      tbl[1].addr[0] = 16'hA001; tbl[1].addr[1] = 16'hA002; tbl[1].addr[2] = 16'hA003; tbl[1].addr[3] = 16'hA004;
      tbl[1].lat[0] = 8'd2; tbl[1].lat[1] = 8'd7; tbl[1].lat[2] = 8'd3; tbl[1].lat[3] = 8'd4;
      tbl[2] = mk(4'd2, 16'h0040, 16'd1, 1, 3, 1);
      tbl[2].addr[0] = 16'h0055; tbl[2].addr[1] = 16'h0066;
      tbl[2].lat[0] = 8'd3; tbl[2].lat[1] = 8'd0;
      tbl[3] = mk(4'd1, 16'hFFFF, 16'd1, 1, 2, 0);
      tbl[3].addr[0] = 16'h0077; tbl[3].lat[0] = 8'd2;
      tbl[4] = mk(4'd12, 16'h0100, 16'd1, 8, 2, 0);
      for (int k = 0; k < 8; k++) begin
         tbl[4].addr[k] = 16'h0200 + 16'(k);
         tbl[4].lat[k]  = 8'd2;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_trace", memory_trace, 0);
      chk("rst_ready", trace_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", run_done, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_issued", issued_count, 0);
      chk("rst_maxlat", max_latency, 0);
      reset = 1'b0;
      @(negedge clk);

      // Zero-length start: run_done two cycles after start, nothing issued
      d0 = done_cnt;
      start = 1'b1; trace_len = '0;
      @(negedge clk); start = 1'b0;
      chk("len0_done_early", run_done, 0);
      chk("len0_busy", busy, 0);
      @(negedge clk);
      chk("len0_done", run_done, 1);
      @(negedge clk);
      chk("len0_done_width", run_done, 0);
      chk("len0_done_count", done_cnt - d0, 1);
      chk("len0_issued", issued_count, 0);

      // Table of runs
      for (int i = 0; i < 5; i++) begin
         arm(tbl[i], 1'b1);
         finish($sformatf("run%0d", i), tbl[i].x_issued, tbl[i].x_max, tbl[i].x_terr);
      end

      // Reset in WAIT: outputs drop at once, no run_done, buffer intact
      load(0, 16'h0AAA);
      load(1, 16'h0BBB);
      exp_addr_q.push_back(16'h0AAA); resp_q.push_back(0);
      start = 1'b1; trace_len = 4'd2;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (trace_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("rstmid_issue_seen", trace_ready, 1);
      repeat (3) @(negedge clk);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      chk("rstmid_ready", trace_ready, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_issued", issued_count, 0);
      @(negedge clk); #2 reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstmid_no_done", done_cnt - d0, 0);
      chk("rstmid_busy_after", busy, 0);
      hr = mk(4'd2, 16'h0300, 16'd1, 2, 3, 0);
      hr.addr[0] = 16'h0AAA; hr.addr[1] = 16'h0BBB; hr.lat[0] = 8'd3; hr.lat[1] = 8'd2;
      arm(hr, 1'b0);
      finish("rstmid_replay", 2, 3, 0);

      // start and load_en while busy are ignored
      hr = mk(4'd2, 16'h0400, 16'd1, 2, 6, 0);
      hr.addr[0] = 16'h0C01; hr.addr[1] = 16'h0C02; hr.lat[0] = 8'd6; hr.lat[1] = 8'd6;
      arm(hr, 1'b1);
      cyc = 0;
      while (trace_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("busy_issue_seen", trace_ready, 1);
      start = 1'b1; trace_len = 4'd5;
      load_en = 1'b1; load_addr = 3'd1; load_data = 16'hDEAD;
      @(negedge clk);
      start = 1'b0; load_en = 1'b0;
      finish("busy_ignore", 2, 6, 0);
      arm(hr, 1'b0);
      finish("busy_buf_intact", 2, 6, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
